// File: rtl/window_averager_if.sv
// Signal bundle between the window averager, its sample source, the
// measurement timer and the downstream consumer of the window results.
interface window_averager_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  localparam int ACC_W = DATA_W + CNT_W;

  logic                     i_en;
  logic                     i_arm;
  logic                     o_timer_start;
  logic                     i_update_flag;
  logic                     i_in_valid;
  logic signed [DATA_W-1:0] i_in_data;
  logic                     o_busy;
  logic                     o_out_valid;
  logic signed [DATA_W-1:0] o_out_mean;
  logic signed [ACC_W-1:0]  o_out_sum;
  logic [CNT_W-1:0]         o_out_count;
  logic                     o_out_sat;
  logic                     o_out_empty;

  // The averager itself
  modport slave (
    input  i_en, i_arm, i_update_flag, i_in_valid, i_in_data,
    output o_timer_start, o_busy, o_out_valid, o_out_mean, o_out_sum,
           o_out_count, o_out_sat, o_out_empty
  );

  // Whatever drives the averager and consumes its results
  modport master (
    output i_en, i_arm, i_update_flag, i_in_valid, i_in_data,
    input  o_timer_start, o_busy, o_out_valid, o_out_mean, o_out_sum,
           o_out_count, o_out_sat, o_out_empty
  );
endinterface

// File: rtl/window_averager.sv
// Window averager: arms the measurement timer, sums valid samples until the
// timer's end-of-window flag, then divides sum by count with a restoring
// divider (one quotient bit per cycle) and publishes mean, sum and count.
module window_averager #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  window_averager_if.slave bus
);
  localparam int ACC_W = DATA_W + CNT_W;
  localparam int BIT_W = $clog2(ACC_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // Window accumulation
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sat;

  // Divider: r_quo starts as |sum| and is shifted left, quotient bits enter at the bottom
  logic [ACC_W-1:0] r_quo;
  logic [CNT_W-1:0] r_rem;
  logic [BIT_W-1:0] r_bit;
  logic             r_neg;

  // Published results
  logic                     r_outValid;
  logic signed [DATA_W-1:0] r_outMean;
  logic signed [ACC_W-1:0]  r_outSum;
  logic [CNT_W-1:0]         r_outCount;
  logic                     r_outSat;
  logic                     r_outEmpty;

  logic                    w_timerStart;
  logic                    w_take;
  logic                    w_drop;
  logic signed [ACC_W-1:0] w_accNext;
  logic [CNT_W-1:0]        w_cntNext;
  logic                    w_satNext;
  logic [ACC_W-1:0]        w_absAcc;
  logic [CNT_W:0]          w_remShift;
  logic [CNT_W-1:0]        w_remDiff;
  logic                    w_remGe;
  logic [DATA_W-1:0]       w_quoLow;

  // Sample acceptance and the divider step; the sample arriving with the
  // end-of-window flag is folded in before the divide starts
  always_comb begin
    w_take     = (r_state == S_ACCUM) && bus.i_in_valid && (r_cnt != CNT_MAX);
    w_drop     = (r_state == S_ACCUM) && bus.i_in_valid && (r_cnt == CNT_MAX);
    w_accNext  = r_acc;
    w_cntNext  = r_cnt;
    if (w_take) begin
      w_accNext = r_acc + {{CNT_W{bus.i_in_data[DATA_W-1]}}, bus.i_in_data};
      w_cntNext = r_cnt + CNT_W'(1);
    end
    w_satNext  = r_sat | w_drop;
    w_absAcc   = w_accNext[ACC_W-1] ? $unsigned(-w_accNext) : $unsigned(w_accNext);
    w_remShift = {r_rem, r_quo[ACC_W-1]};
    w_remGe    = (w_remShift >= {1'b0, r_cnt});
    w_remDiff  = CNT_W'(w_remShift - {1'b0, r_cnt});
    w_quoLow   = r_quo[DATA_W-1:0];
  end

  // Next-state logic and the timer start pulse
  always_comb begin
    w_stateNext  = r_state;
    w_timerStart = 1'b0;
    if (bus.i_en) begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_arm) begin
            w_stateNext  = S_ACCUM;
            w_timerStart = 1'b1;
          end
        end
        S_ACCUM: begin
          if (bus.i_update_flag) begin
            w_stateNext = (w_cntNext == '0) ? S_DONE : S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (r_bit == LAST_BIT) begin
            w_stateNext = S_DONE;
          end
        end
        S_DONE: begin
          w_stateNext = S_IDLE;
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // State register; holds while the block is disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (bus.i_en) begin
      r_state <= w_stateNext;
    end
  end

  // Accumulator, divider and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_bit      <= '0;
      r_neg      <= 1'b0;
      r_outValid <= 1'b0;
      r_outMean  <= '0;
      r_outSum   <= '0;
      r_outCount <= '0;
      r_outSat   <= 1'b0;
      r_outEmpty <= 1'b0;
    end else if (!bus.i_en) begin
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_arm) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
          end
        end
        S_ACCUM: begin
          r_acc <= w_accNext;
          r_cnt <= w_cntNext;
          r_sat <= w_satNext;
          if (bus.i_update_flag) begin
            r_quo <= w_absAcc;
            r_neg <= w_accNext[ACC_W-1];
            r_rem <= '0;
            r_bit <= '0;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_remGe ? w_remDiff : w_remShift[CNT_W-1:0];
          r_quo <= {r_quo[ACC_W-2:0], w_remGe};
          r_bit <= r_bit + 1'b1;
        end
        S_DONE: begin
          r_outMean  <= r_neg ? (~w_quoLow + 1'b1) : w_quoLow;
          r_outSum   <= r_acc;
          r_outCount <= r_cnt;
          r_outSat   <= r_sat;
          r_outEmpty <= (r_cnt == '0);
          r_outValid <= 1'b1;
        end
        default: begin
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_timer_start = w_timerStart & ~rst;
  assign bus.o_busy        = (r_state != S_IDLE);
  assign bus.o_out_valid   = r_outValid;
  assign bus.o_out_mean    = r_outMean;
  assign bus.o_out_sum     = r_outSum;
  assign bus.o_out_count   = r_outCount;
  assign bus.o_out_sat     = r_outSat;
  assign bus.o_out_empty   = r_outEmpty;
endmodule

// File: tb/tb_window_averager.sv
// Scoreboard bench for the window averager: a default-width instance (A) and a
// narrow-counter instance (B) are driven with directed and random windows;
// expected results come from plain sum/count arithmetic over the samples sent.
module tb_window_averager;
  localparam int ACC_W_A = 32;
  localparam int ACC_W_B = 20;
  localparam int MAX_A   = 65535;
  localparam int MAX_B   = 15;

  typedef struct {
    int     due;
    longint mean;
    longint sum;
    longint count;
    longint sat;
    longint empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qA[$];
  exp_t qB[$];
  int   stim[$];
  int   tsCnt[2];
  int   arms[2];
  bit   prevValid[2];

  window_averager_if #(.DATA_W(16), .CNT_W(16)) busA ();
  window_averager_if #(.DATA_W(16), .CNT_W(4))  busB ();

  window_averager #(.DATA_W(16), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(busA));
  window_averager #(.DATA_W(16), .CNT_W(4))  dutB (.clk(clk), .rst(rst), .bus(busB));

  // Free-running clock and edge counter used for latency checks
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
    end
  endtask

  // One cycle of input on the selected instance, applied just after a rising edge
  task automatic applyStimulus(input int sel, input bit en, input bit arm, input bit vld,
                               input int data, input bit upd);
    @(posedge clk);
    #2;
    if (sel == 0) begin
      busA.i_en = en; busA.i_arm = arm; busA.i_in_valid = vld;
      busA.i_in_data = 16'(data); busA.i_update_flag = upd;
    end else begin
      busB.i_en = en; busB.i_arm = arm; busB.i_in_valid = vld;
      busB.i_in_data = 16'(data); busB.i_update_flag = upd;
    end
  endtask

  // Reference result: the first max samples count, the mean truncates toward zero
  task automatic pushExpected(input int sel, input int s[$]);
    exp_t   e;
    longint sum = 0;
    int     maxCnt = (sel == 0) ? MAX_A : MAX_B;
    int     lat = (sel == 0) ? ACC_W_A + 1 : ACC_W_B + 1;
    int     n = (s.size() > maxCnt) ? maxCnt : s.size();
    for (int i = 0; i < n; i++) sum += s[i];
    e.sum   = sum;
    e.count = n;
    e.sat   = (s.size() > maxCnt) ? 1 : 0;
    e.empty = (n == 0) ? 1 : 0;
    e.mean  = (n == 0) ? 0 : sum / n;
    e.due   = cyc + 1 + ((n == 0) ? 1 : lat);
    if (sel == 0) qA.push_back(e);
    else qB.push_back(e);
  endtask

  // Arm, feed the samples in stim with random gaps, then end the window
  task automatic runWindow(input int sel, input bit coincident, input int gateCycles);
    int n = stim.size();
    applyStimulus(sel, 1, 1, 0, 0, 0);
    arms[sel]++;
    @(negedge clk);
    checkOutput("timer_start on arm", (sel == 0) ? busA.o_timer_start : busB.o_timer_start, 1);
    checkOutput("busy in idle", (sel == 0) ? busA.o_busy : busB.o_busy, 0);
    for (int i = 0; i < n; i++) begin
      if (coincident && i == n - 1) begin
        applyStimulus(sel, 1, 0, 1, stim[i], 1);
        pushExpected(sel, stim);
      end else begin
        repeat ($urandom_range(0, 2)) applyStimulus(sel, 1, 0, 0, int'($urandom), 0);
        applyStimulus(sel, 1, 0, 1, stim[i], 0);
        if (i == 0) begin
          repeat (gateCycles) applyStimulus(sel, 0, $urandom_range(0, 1), 1, 1000,
                                            $urandom_range(0, 1));
        end
      end
    end
    if (!coincident || n == 0) begin
      applyStimulus(sel, 1, 0, 0, 0, 1);
      pushExpected(sel, stim);
    end
    @(negedge clk);
    checkOutput("busy in accum", (sel == 0) ? busA.o_busy : busB.o_busy, 1);
    applyStimulus(sel, 1, 0, 0, 0, 0);
  endtask

  // Bounded wait for every issued window to be reported
  task automatic waitDrain();
    int k = 0;
    while ((qA.size() + qB.size()) != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if ((qA.size() + qB.size()) != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: got %0d results outstanding required 0",
               qA.size() + qB.size());
      qA.delete();
      qB.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkResetState();
    checkOutput("reset out_valid", busA.o_out_valid, 0);
    checkOutput("reset out_mean", busA.o_out_mean, 0);
    checkOutput("reset out_sum", busA.o_out_sum, 0);
    checkOutput("reset out_count", busA.o_out_count, 0);
    checkOutput("reset out_sat", busA.o_out_sat, 0);
    checkOutput("reset out_empty", busA.o_out_empty, 0);
    checkOutput("reset busy", busA.o_busy, 0);
    checkOutput("reset timer_start", busA.o_timer_start, 0);
    checkOutput("reset B out_count", busB.o_out_count, 0);
  endtask

  // Monitor half: compares whatever the selected instance presents with the queue head
  task automatic monitorBus(input int sel);
    exp_t   e;
    string  tag = (sel == 0) ? "A" : "B";
    bit     v = (sel == 0) ? busA.o_out_valid : busB.o_out_valid;
    longint mean = (sel == 0) ? $signed(busA.o_out_mean) : $signed(busB.o_out_mean);
    longint sum = (sel == 0) ? $signed(busA.o_out_sum) : $signed(busB.o_out_sum);
    longint count = (sel == 0) ? busA.o_out_count : busB.o_out_count;
    if ((sel == 0) ? busA.o_timer_start : busB.o_timer_start) tsCnt[sel]++;
    if (v) begin
      checkOutput({tag, " out_valid back-to-back"}, prevValid[sel], 0);
      if (((sel == 0) ? qA.size() : qB.size()) == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s unexpected out_valid: got 1 required 0", tag);
      end else begin
        if (sel == 0) e = qA.pop_front();
        else e = qB.pop_front();
        checkOutput({tag, " latency cycle"}, cyc, e.due);
        checkOutput({tag, " out_mean"}, mean, e.mean);
        checkOutput({tag, " out_sum"}, sum, e.sum);
        checkOutput({tag, " out_count"}, count, e.count);
        checkOutput({tag, " out_sat"}, (sel == 0) ? busA.o_out_sat : busB.o_out_sat, e.sat);
        checkOutput({tag, " out_empty"}, (sel == 0) ? busA.o_out_empty : busB.o_out_empty,
                    e.empty);
      end
    end
    prevValid[sel] = v;
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    monitorBus(0);
    monitorBus(1);
  end

  // Hard stop in case the stimulus itself wedges
  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: got no finish required finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed cases first, then random windows, then the narrow-counter instance
  initial begin
    busA.i_en = 1'b1; busA.i_arm = 1'b0; busA.i_in_valid = 1'b0;
    busA.i_in_data = '0; busA.i_update_flag = 1'b0;
    busB.i_en = 1'b1; busB.i_arm = 1'b0; busB.i_in_valid = 1'b0;
    busB.i_in_data = '0; busB.i_update_flag = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkResetState();

    stim = '{10, 20, 30, 40};
    runWindow(0, 0, 0);
    waitDrain();

    stim = '{-7, -8};
    runWindow(0, 0, 0);
    waitDrain();

    stim.delete();
    runWindow(0, 0, 0);
    waitDrain();

    stim = '{5};
    runWindow(0, 1, 0);
    waitDrain();

    repeat (4) applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("stray flag keeps idle", busA.o_busy, 0);

    stim = '{100, 200, -50};
    runWindow(0, 0, 3);
    waitDrain();

    stim = '{-32768, -32768, -32767};
    runWindow(0, 0, 0);
    waitDrain();

    stim = '{32767, 32767, 32766};
    runWindow(0, 1, 0);
    waitDrain();

    for (int w = 0; w < 12; w++) begin
      stim.delete();
      repeat ($urandom_range(0, 8)) stim.push_back(int'($signed(16'($urandom))));
      runWindow(0, $urandom_range(0, 1), $urandom_range(0, 2));
      waitDrain();
    end

    applyStimulus(0, 1, 1, 0, 0, 0);
    arms[0]++;
    applyStimulus(0, 1, 0, 1, 3, 0);
    applyStimulus(0, 1, 0, 1, 4, 1);
    repeat (5) applyStimulus(0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkResetState();
    repeat (40) applyStimulus(0, 1, 0, 0, 0, 0);

    stim = '{1, 2, 3};
    runWindow(0, 0, 0);
    waitDrain();

    stim.delete();
    repeat (20) stim.push_back(1);
    runWindow(1, 0, 0);
    waitDrain();

    stim = '{-3, 2};
    runWindow(1, 0, 0);
    waitDrain();

    stim.delete();
    repeat (18) stim.push_back(int'($signed(16'($urandom))));
    runWindow(1, 1, 0);
    waitDrain();

    @(negedge clk);
    checkOutput("A timer_start pulse total", tsCnt[0], arms[0]);
    checkOutput("B timer_start pulse total", tsCnt[1], arms[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_averager.md
Name: window_averager

Overview:
- Consumer of the periodic measurement timer.
- Arms the timer with a one-cycle start pulse, then accumulates valid input samples until the timer's update flag fires.
- When the flag fires, computes the window mean with a sequential divider and presents the mean, sum and sample count for one-cycle consumption.
- Sits between the sample source and the downstream PSD/update logic.

Parameters:
- DATA_W, 16, signed sample width; out_mean has the same width.
- CNT_W, 16, sample counter width; the counter saturates at 2^CNT_W-1.
- ACC_W is derived (DATA_W+CNT_W). It is a localparam, not overridable.

Ports:
- clk  input  1  system clock, the single clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable. When low, state and all registers hold.
- arm  input  1  level request to start a measurement window.
- timer_start  output  1  one-cycle pulse to the timer's start input.
- update_flag  input  1  end-of-window pulse from the timer.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  signed sample.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  one-cycle pulse: the result registers were updated this cycle.
- out_mean  output  DATA_W  signed mean, truncated toward zero.
- out_sum  output  ACC_W  signed window sum.
- out_count  output  CNT_W  number of accepted samples.
- out_sat  output  1  the count saturated during the window.
- out_empty  output  1  the window contained zero samples.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge, any state):
  - state goes to IDLE.
  - Accumulator, counter and divider registers clear.
  - All outputs are 0.
  - A divide in progress is aborted; no out_valid is produced.
- en=0: nothing changes, timer_start=0, in_valid and update_flag are ignored. Registered outputs hold; out_valid is forced 0.
- Operation is defined for en=1.
- IDLE:
  - If arm=1: timer_start=1 for exactly this one cycle, acc<=0, cnt<=0, sat<=0, go to ACCUM.
  - update_flag is ignored.
- ACCUM:
  - in_valid=1 with cnt<max: acc += sign-extended in_data, cnt += 1.
  - in_valid=1 with cnt==max: the sample is dropped and sat<=1.
  - A sample with in_valid=1 in the same cycle as update_flag=1 is included.
  - update_flag=1 and final cnt==0: go to DONE with mean=0 and empty=1.
  - update_flag=1 otherwise: go to DIVIDE.
  - arm is ignored.
- DIVIDE:
  - Restoring unsigned divide of |acc| by cnt, one quotient bit per cycle, ACC_W cycles.
  - The result is then negated if acc<0, so rounding is toward zero.
  - The result is taken as the low DATA_W bits, which is exact because |mean| <= max|in_data|.
  - update_flag, in_valid and arm are ignored.
- DONE (one cycle):
  - out_mean, out_sum, out_count, out_sat and out_empty load; out_valid=1.
  - Outputs then hold until the next DONE or reset.
  - Next state is always IDLE, so a continuously high arm re-arms one cycle later.
- Latency, with update_flag sampled at edge T:
  - Normal window: out_valid high in cycle T+ACC_W+1.
  - Empty window: out_valid high in cycle T+1.
- timer_start is asserted only on the IDLE->ACCUM transition, never twice per window.
- busy=1 in ACCUM, DIVIDE and DONE.
- out_valid is never high in two consecutive cycles.

Test Plan:
All cases use the defaults (DATA_W=16, ACC_W=32) unless noted.
- Basic mean:
  - Stimulus: rst, then arm pulse; samples 10, 20, 30, 40; then update_flag at edge T.
  - Required: one timer_start pulse; out_valid at T+33 with mean=25, sum=100, count=4, sat=0, empty=0.
- Negative rounding:
  - Stimulus: samples -7, -8; then update.
  - Required: sum=-15, mean=-7 (toward zero, not -8), count=2.
- Empty window:
  - Stimulus: arm, then update_flag with no in_valid.
  - Required: out_valid at T+1 with mean=0, sum=0, count=0, empty=1.
- Same-cycle sample and stray flag:
  - Stimulus: in_valid=1 (data 5) coincident with update_flag; separately, update_flag in IDLE.
  - Required: the coincident sample is counted, giving count=1 and mean=5. The IDLE flag gives no state change and no out_valid.
- Enable and reset mid-operation:
  - Stimulus: en=0 for 3 cycles in ACCUM while in_valid=1; then rst asserted in DIVIDE.
  - Required: the gated samples are not counted. After reset: IDLE, all outputs 0, no out_valid.
- Saturation (CNT_W=4):
  - Stimulus: 20 samples of value 1, then update.
  - Required: count=15, sat=1, sum=15, mean=1.
